// File: rtl/board_io_ctrl.sv
// board_io_ctrl: Avalon-MM slave for seven-segment digits, LEDs, switches and pushbuttons.
// Define BOARD_IO_DEBOUNCE_EN to build the per-key debounce FSMs; otherwise keys are only synchronised.
module board_io_ctrl #(
  parameter int NUM_HEX         = 6,
  parameter int NUM_LEDS        = 10,
  parameter int NUM_SW          = 10,
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  irq,
  input  logic [NUM_SW-1:0]     sw_in,
  input  logic [NUM_KEYS-1:0]   key_in,
  output logic [NUM_LEDS-1:0]   led_out,
  output logic [7*NUM_HEX-1:0]  hex_segs
);
  logic [NUM_SW-1:0]   sw_s1, sw_s2;
  logic [NUM_KEYS-1:0] key_s1, key_s2;
  logic [NUM_KEYS-1:0] key_state, key_state_nx;
  logic [NUM_KEYS-1:0] key_edge, key_mask, edge_clr;
  logic [NUM_LEDS-1:0] led_reg;
  logic [63:0]         hex_bytes;
  logic                decode;
  logic [31:0]         rd_mux;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
    endcase
  endfunction

  assign edge_clr = (write && address == 3'd5) ? writedata[NUM_KEYS-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1     <= '0;
      sw_s2     <= '0;
      key_s1    <= '0;
      key_s2    <= '0;
      led_reg   <= '0;
      hex_bytes <= '0;
      decode    <= 1'b0;
      key_mask  <= '0;
      key_edge  <= '0;
      irq       <= 1'b0;
      readdata  <= '0;
    end else begin
      sw_s1  <= sw_in;
      sw_s2  <= sw_s1;
      key_s1 <= key_in;
      key_s2 <= key_s1;
      if (write) begin
        case (address)
          3'd1: led_reg <= writedata[NUM_LEDS-1:0];
          3'd2: for (int k = 0; k < 4; k++)
                  if (k < NUM_HEX) hex_bytes[8*k +: 8] <= writedata[8*k +: 8];
          3'd3: for (int k = 0; k < 4; k++)
                  if (k + 4 < NUM_HEX) hex_bytes[8*(k+4) +: 8] <= writedata[8*k +: 8];
          3'd6: key_mask <= writedata[NUM_KEYS-1:0];
          3'd7: decode <= writedata[0];
          default: ;
        endcase
      end
      // A new press edge outranks a same-cycle write-one-to-clear.
      key_edge <= (key_edge & ~edge_clr) | (key_state_nx & ~key_state);
      irq      <= |(key_edge & key_mask);
      if (read) readdata <= rd_mux;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0: rd_mux[NUM_SW-1:0]   = sw_s2;
      3'd1: rd_mux[NUM_LEDS-1:0] = led_reg;
      3'd2: rd_mux               = hex_bytes[31:0];
      3'd3: rd_mux               = hex_bytes[63:32];
      3'd4: rd_mux[NUM_KEYS-1:0] = key_state;
      3'd5: rd_mux[NUM_KEYS-1:0] = key_edge;
      3'd6: rd_mux[NUM_KEYS-1:0] = key_mask;
      default: rd_mux[0]         = decode;
    endcase
  end

  always_comb begin
    hex_segs = '0;
    for (int k = 0; k < NUM_HEX; k++)
      hex_segs[7*k +: 7] = decode ? seg7(hex_bytes[8*k +: 4]) : hex_bytes[8*k +: 7];
  end

  assign led_out = led_reg;

`ifdef BOARD_IO_DEBOUNCE_EN
  // state     | meaning
  // ST_STABLE | debounced level matches the synchronised input
  // ST_COUNT  | input differs, counting consecutive stable cycles
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_STABLE = 1'b0, ST_COUNT = 1'b1} db_state_t;

  db_state_t           db_st    [NUM_KEYS];
  db_state_t           db_st_nx [NUM_KEYS];
  logic [CW-1:0]       db_cnt    [NUM_KEYS];
  logic [CW-1:0]       db_cnt_nx [NUM_KEYS];
  logic [NUM_KEYS-1:0] db_diff, db_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_st[i]  <= ST_STABLE;
        db_cnt[i] <= '0;
      end
      key_state <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_st[i]  <= db_st_nx[i];
        db_cnt[i] <= db_cnt_nx[i];
      end
      key_state <= key_state_nx;
    end
  end

  // Accept on the edge that completes DEBOUNCE_CYCLES stable cycles, counting the entry cycle.
  always_comb begin
    db_diff = '0;
    db_done = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      db_diff[i] = key_s2[i] != key_state[i];
      db_done[i] = db_diff[i] &&
                   ((db_st[i] == ST_STABLE && DEBOUNCE_CYCLES == 1) ||
                    (db_st[i] == ST_COUNT && db_cnt[i] + CW'(1) == CNT_LAST));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      db_st_nx[i]  = db_st[i];
      db_cnt_nx[i] = db_cnt[i];
      case (db_st[i])
        ST_STABLE: if (db_diff[i] && !db_done[i]) begin
          db_st_nx[i]  = ST_COUNT;
          db_cnt_nx[i] = '0;
        end
        default: if (!db_diff[i] || db_done[i]) db_st_nx[i] = ST_STABLE;
                 else db_cnt_nx[i] = db_cnt[i] + CW'(1);
      endcase
    end
  end

  always_comb begin
    key_state_nx = key_state;
    for (int i = 0; i < NUM_KEYS; i++)
      if (db_done[i]) key_state_nx[i] = key_s2[i];
  end
`else
  assign key_state    = key_s2;
  assign key_state_nx = key_s1;
`endif

endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Parametrised Avalon-MM slave for the board's user I/O: seven-segment digits, LEDs, slider switches and pushbuttons. It is the next generation of the fixed-width PIO set in the HPS system: one register block serves any digit, LED, switch and key count. It adds per-key debounce, press edge capture with a maskable interrupt, and an optional hardware hex-to-segment decode. It is instantiated inside the HPS system and clocked from CLOCK_50; the board top inverts `hex_segs` for the active-low displays.

## Interface
- `NUM_HEX`, 6: seven-segment digits, range 1..8.
- `NUM_LEDS`, 10: LED outputs, range 1..32.
- `NUM_SW`, 10: switch inputs, range 1..32.
- `NUM_KEYS`, 4: pushbutton inputs, range 1..32, active-high at this port.
- `DEBOUNCE_CYCLES`, 500000: stable cycles required before a key change is accepted (10 ms at 50 MHz); minimum 1.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  3  word address.
- `read`  in  1  read strobe.
- `write`  in  1  write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  read data, registered.
- `irq`  out  1  key interrupt, level.
- `sw_in`  in  NUM_SW  raw switches, asynchronous.
- `key_in`  in  NUM_KEYS  raw keys, asynchronous, already inverted to active-high.
- `led_out`  out  NUM_LEDS  LED drive.
- `hex_segs`  out  7*NUM_HEX  active-high segments; digit k occupies [7k+6:7k], bit order gfedcba.

## Operation
- Register map. Unused bits read 0. Writes to RO registers are ignored.
  - 0 SW (RO): synchronised switches.
  - 1 LED (RW): bits [NUM_LEDS-1:0].
  - 2 HEX_LO (RW): byte k holds digit k, k = 0..3.
  - 3 HEX_HI (RW): byte k holds digit 4+k. Bytes for digits ≥ NUM_HEX are not stored.
  - 4 KEY_STATE (RO): debounced key levels.
  - 5 KEY_EDGE (R/W1C): captured press edges.
  - 6 KEY_MASK (RW): interrupt enables.
  - 7 CTRL (RW): bit0 DECODE.
- Every asynchronous input goes through a 2-flop synchroniser.
- HEX output:
  - DECODE=0: `hex_segs` digit k = bits [6:0] of its byte; bit 7 is stored but not displayed.
  - DECODE=1: bits [3:0] of the byte are decoded 0-F to standard segments: 0=0x3F, 1=0x06, 8=0x7F, A=0x77, F=0x71.
  - Output is combinational from registers plus DECODE.
- Per-key debounce, two-state FSM, counter width $clog2(DEBOUNCE_CYCLES+1):
  - STABLE: if synchronised input ≠ debounced state, clear the counter and go to COUNT.
  - COUNT: if the input returns to the debounced value, go to STABLE. Otherwise increment. When the counter reaches DEBOUNCE_CYCLES-1, update the debounced state and go to STABLE.
- Edge capture: a debounced 0→1 transition sets KEY_EDGE[i]. Release does not.
- Writing 1 to KEY_EDGE[i] clears it. If a set and a clear of the same bit occur in the same cycle, set wins.
- `irq` = |(KEY_EDGE & KEY_MASK), registered.
- Simultaneous read and write to the same address: read returns the pre-write value.

## Timing
- Reset clears all registers, synchronisers, debounce state and counters: `readdata`=0, `irq`=0, `led_out`=0, `hex_segs`=0.
- Write takes effect at the clk edge where `write`=1. `led_out` and `hex_segs` change on that edge.
- Read latency is fixed at 1 cycle: `readdata` is valid the cycle after `read`. There is no waitrequest. `readdata` holds its value when `read`=0.
- SW register lags `sw_in` by 2 cycles.
- Key press to KEY_STATE change: 2 synchroniser cycles + DEBOUNCE_CYCLES. KEY_EDGE sets on that same edge; `irq` follows 1 cycle later.
- Reset asserted mid-debounce aborts the count. No edge is captured until the input is stable again.

## Configuration
- `BOARD_IO_DEBOUNCE_EN`:
  - Defined: debounce FSM and counters are built as described above.
  - Undefined: KEY_STATE = synchronised key input directly; edges are detected on that signal; DEBOUNCE_CYCLES is ignored; press-to-state latency is 2 cycles.

## Test plan
- Reset, then read all 8 addresses → all read 0 except SW, which reads the `sw_in` value applied ≥2 cycles earlier. `irq`=0, `hex_segs`=0.
- Write LED=0x3FF, HEX_LO=0x7F06_3F5B, NUM_HEX=6 → `led_out`=0x3FF; digits 0..3 = 0x5B, 0x3F, 0x06, 0x7F. Read back LED and HEX_LO 1 cycle after `read` → same values.
- CTRL=1, HEX_LO=0x0F0A_0801 → digits 0..3 = 0x06, 0x7F, 0x77, 0x71.
- DEBOUNCE_CYCLES=8: pulse key 0 for 5 cycles → no KEY_STATE change. Hold it for 12 cycles → KEY_STATE[0]=1 and KEY_EDGE[0]=1 exactly 10 cycles after the input rises.
- KEY_MASK=1, press key 0 → `irq`=1. Write KEY_EDGE=1 → `irq`=0 two cycles later. Repeat with a W1C landing on the same cycle as a new edge → bit stays 1.
- Assert reset for 1 cycle while the key 0 counter is at 5 → all state returns to 0 and no edge is captured. With `BOARD_IO_DEBOUNCE_EN` undefined, a 1-cycle key pulse sets KEY_EDGE.
